// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: port index, read-return tag
// and the maximum supported memory latency.
package mem_arb_pkg;

  typedef logic port_t;

  typedef struct packed {
    logic  valid;
    port_t port;
  } tag_t;

  localparam int MEM_LAT_MAX = 4;

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// Latency-matched shift register of read-return tags; the last stage lines up
// with the cycle in which the memory presents the read data.
module mem_arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t i_tag,
  output tag_t o_tag
);

  tag_t [DEPTH-1:0] r_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag <= '0;
    end else begin
      r_tag <= {r_tag[DEPTH-2:0], i_tag};
    end
  end

  assign o_tag = r_tag[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter with registered issue and tagged read return.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 wins ties.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              rvalid0_o,
  output logic              rvalid1_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int TAG_DEPTH = ((MEM_LAT < MEM_LAT_MAX) ? MEM_LAT : MEM_LAT_MAX) + 1;

  logic  w_gnt0;
  logic  w_gnt1;
  logic  w_any;
  port_t w_sel;
  logic  w_we_sel;
  tag_t  w_tag_in;
  tag_t  w_tag_out;

`ifdef MEM_ARB_RR_EN
  // Last-granted port; resets to 1 so port 0 takes the first tie.
  port_t r_last;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (reset) begin
      if (req0_i && req1_i) begin
        w_gnt0 = (r_last == 1'b1);
        w_gnt1 = (r_last == 1'b0);
      end else begin
        w_gnt0 = req0_i;
        w_gnt1 = req1_i;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last <= 1'b1;
    end else if (w_any) begin
      r_last <= w_sel;
    end
  end
`else
  always_comb begin
    w_gnt0 = reset & req0_i;
    w_gnt1 = reset & req1_i & ~req0_i;
  end
`endif

  assign gnt0_o   = w_gnt0;
  assign gnt1_o   = w_gnt1;
  assign w_any    = w_gnt0 | w_gnt1;
  assign w_sel    = w_gnt1;
  assign w_we_sel = w_sel ? we1_i : we0_i;

  // Issue stage: address/data hold when idle, only the write strobe drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      mem_we_o <= w_any & w_we_sel;
      if (w_any) begin
        mem_addr_o  <= w_sel ? addr1_i  : addr0_i;
        mem_wdata_o <= w_sel ? wdata1_i : wdata0_i;
      end
    end
  end

  always_comb begin
    w_tag_in       = '0;
    w_tag_in.valid = w_any & ~w_we_sel;
    w_tag_in.port  = w_sel;
  end

  mem_arb_tag_pipe #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_pipe (
    .clk   (clk),
    .rst_n (reset),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  assign rvalid0_o = w_tag_out.valid & (w_tag_out.port == 1'b0);
  assign rvalid1_o = w_tag_out.valid & (w_tag_out.port == 1'b1);
  assign rdata0_o  = rvalid0_o ? mem_rdata_i : '0;
  assign rdata1_o  = rvalid1_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3) share stimulus
// and are compared every cycle against a queue-based model; directed cases pin it.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;

  logic        gnt0   [2];
  logic        gnt1   [2];
  logic        rvalid0[2];
  logic        rvalid1[2];
  logic [31:0] rdata0 [2];
  logic [31:0] rdata1 [2];
  logic        mem_we [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata[2];
  logic [31:0] mem_rdata[2];

  int n_chk = 0;
  int n_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset),
    .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .gnt0_o(gnt0[0]), .gnt1_o(gnt1[0]),
    .rvalid0_o(rvalid0[0]), .rvalid1_o(rvalid1[0]),
    .rdata0_o(rdata0[0]), .rdata1_o(rdata1[0]),
    .mem_we_o(mem_we[0]), .mem_addr_o(mem_addr[0]), .mem_wdata_o(mem_wdata[0]),
    .mem_rdata_i(mem_rdata[0])
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_lat3 (
    .clk(clk), .reset(reset),
    .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .gnt0_o(gnt0[1]), .gnt1_o(gnt1[1]),
    .rvalid0_o(rvalid0[1]), .rvalid1_o(rvalid1[1]),
    .rdata0_o(rdata0[1]), .rdata1_o(rdata1[1]),
    .mem_we_o(mem_we[1]), .mem_addr_o(mem_addr[1]), .mem_wdata_o(mem_wdata[1]),
    .mem_rdata_i(mem_rdata[1])
  );

  function automatic logic [31:0] init_word(input int a);
    return (a == 16) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(a));
  endfunction

  // Memory devices: sample address at the edge, return data MEM_LAT cycles later.
  for (genvar k = 0; k < 2; k++) begin : g_mem
    localparam int L = (k == 0) ? 1 : 3;
    logic [31:0] dm [256];
    logic [31:0] rq [4];
    initial begin
      for (int a = 0; a < 256; a++) dm[a] = init_word(a);
      for (int i = 0; i < 4; i++) rq[i] = 32'h0;
      forever begin
        @(posedge clk);
        for (int i = 3; i > 0; i--) rq[i] = rq[i-1];
        rq[0] = dm[mem_addr[k][7:0]];
        if (mem_we[k]) dm[mem_addr[k][7:0]] = mem_wdata[k];
      end
    end
    assign mem_rdata[k] = rq[L-1];
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[dut%0d]: got %h expected %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Reference model: expected grants, issue registers and scheduled read returns.
  typedef struct {
    logic        v;
    logic        p;
    logic [31:0] d;
  } sch_t;

  sch_t        sch [2][8];
  logic [31:0] refm [256];
  logic        m_last;
  logic        m_we;
  logic [31:0] m_addr, m_wdata;

  initial begin
    int          cyc;
    int          slot;
    logic        eg0, eg1, ev0, ev1, wp, wwe;
    logic [31:0] wa, wd;
    cyc = 0;
    for (int a = 0; a < 256; a++) refm[a] = init_word(a);
    for (int k = 0; k < 2; k++)
      for (int s = 0; s < 8; s++) sch[k][s] = '{1'b0, 1'b0, 32'h0};
    m_last = 1'b1; m_we = 1'b0; m_addr = 32'h0; m_wdata = 32'h0;
    forever begin
      @(negedge clk);
      eg0 = 1'b0;
      eg1 = 1'b0;
      if (!reset) begin
        for (int k = 0; k < 2; k++)
          for (int s = 0; s < 8; s++) sch[k][s] = '{1'b0, 1'b0, 32'h0};
        m_last = 1'b1; m_we = 1'b0; m_addr = 32'h0; m_wdata = 32'h0;
      end else if (req0 && req1) begin
`ifdef MEM_ARB_RR_EN
        eg0 = m_last;
        eg1 = !m_last;
`else
        eg0 = 1'b1;
`endif
      end else begin
        eg0 = req0;
        eg1 = req1;
      end
      slot = cyc % 8;
      for (int k = 0; k < 2; k++) begin
        ev0 = sch[k][slot].v && !sch[k][slot].p;
        ev1 = sch[k][slot].v &&  sch[k][slot].p;
        chk("gnt0",    k, 32'(gnt0[k]),    32'(eg0));
        chk("gnt1",    k, 32'(gnt1[k]),    32'(eg1));
        chk("rvalid0", k, 32'(rvalid0[k]), 32'(ev0));
        chk("rvalid1", k, 32'(rvalid1[k]), 32'(ev1));
        chk("rdata0",  k, rdata0[k], ev0 ? sch[k][slot].d : 32'h0);
        chk("rdata1",  k, rdata1[k], ev1 ? sch[k][slot].d : 32'h0);
        chk("mem_we",    k, 32'(mem_we[k]), 32'(m_we));
        chk("mem_addr",  k, mem_addr[k],  m_addr);
        chk("mem_wdata", k, mem_wdata[k], m_wdata);
        sch[k][slot].v = 1'b0;
      end
      if (eg0 || eg1) begin
        wp  = eg1;
        wwe = wp ? we1 : we0;
        wa  = wp ? addr1 : addr0;
        wd  = wp ? wdata1 : wdata0;
        m_we = wwe; m_addr = wa; m_wdata = wd; m_last = wp;
        if (wwe) refm[wa[7:0]] = wd;
        else begin
          sch[0][(cyc + 2) % 8] = '{1'b1, wp, refm[wa[7:0]]};
          sch[1][(cyc + 4) % 8] = '{1'b1, wp, refm[wa[7:0]]};
        end
      end else begin
        m_we = 1'b0;
      end
      cyc++;
    end
  end

  task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    @(posedge clk);
    #1;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int          g0c, g1c, alt_bad, rv0c, rv1c, cnt;
    logic        prevg, g0s, g1s;
    logic        rv0 [8];
    logic        rv1 [8];
    logic [31:0] rd0 [8];
    logic [31:0] rd1 [8];

    reset = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Lone port-0 read of 0x10 on the MEM_LAT=1 instance
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t1_gnt0", 0, 32'(gnt0[0]), 32'h1);
    idle();
    @(negedge clk);
    chk("t1_mem_addr", 0, mem_addr[0], 32'h10);
    chk("t1_mem_we",   0, 32'(mem_we[0]), 32'h0);
    idle();
    @(negedge clk);
    chk("t1_rvalid0", 0, 32'(rvalid0[0]), 32'h1);
    chk("t1_rdata0",  0, rdata0[0], 32'hDEADBEEF);
    chk("t1_rvalid1", 0, 32'(rvalid1[0]), 32'h0);
    repeat (4) idle();

    // Both ports read every cycle for 8 cycles
    g0c = 0; g1c = 0; alt_bad = 0; rv0c = 0; rv1c = 0; prevg = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 32'h40 + 32'(g0c), 32'h0, 1'b1, 1'b0, 32'h80 + 32'(g1c), 32'h0);
      @(negedge clk);
      if (gnt0[0]) g0c++;
      if (gnt1[0]) g1c++;
      if (i > 0 && gnt1[0] == prevg) alt_bad++;
      prevg = gnt1[0];
      if (rvalid0[0]) rv0c++;
      if (rvalid1[0]) rv1c++;
    end
    for (int i = 0; i < 6; i++) begin
      idle();
      @(negedge clk);
      if (rvalid0[0]) rv0c++;
      if (rvalid1[0]) rv1c++;
    end
`ifdef MEM_ARB_RR_EN
    chk("t2_gnt0_count", 0, 32'(g0c), 32'd4);
    chk("t2_gnt1_count", 0, 32'(g1c), 32'd4);
    chk("t2_alternation", 0, 32'(alt_bad), 32'd0);
    chk("t2_rvalid0_count", 0, 32'(rv0c), 32'd4);
    chk("t2_rvalid1_count", 0, 32'(rv1c), 32'd4);
`else
    chk("t2_gnt0_count", 0, 32'(g0c), 32'd8);
    chk("t2_gnt1_count", 0, 32'(g1c), 32'd0);
    chk("t2_rvalid0_count", 0, 32'(rv0c), 32'd8);
    chk("t2_rvalid1_count", 0, 32'(rv1c), 32'd0);
`endif

    // Port 1 writes 0x55 to 0x20, then idle for 5 cycles
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h55);
    @(negedge clk);
    chk("t3_gnt1", 0, 32'(gnt1[0]), 32'h1);
    idle();
    @(negedge clk);
    chk("t3_mem_we",    0, 32'(mem_we[0]), 32'h1);
    chk("t3_mem_addr",  0, mem_addr[0],  32'h20);
    chk("t3_mem_wdata", 0, mem_wdata[0], 32'h55);
    cnt = 0; rv0c = 0;
    for (int i = 0; i < 5; i++) begin
      idle();
      @(negedge clk);
      if (mem_we[0]) cnt++;
      if (rvalid0[0] || rvalid1[0] || rvalid0[1] || rvalid1[1]) rv0c++;
    end
    chk("t3_we_after", 0, 32'(cnt), 32'd0);
    chk("t3_addr_hold", 0, mem_addr[0], 32'h20);
    chk("t3_no_rvalid", 0, 32'(rv0c), 32'd0);

    // MEM_LAT=3: read p0, write p1, read p1 on consecutive cycles
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t4_gnt0", 1, 32'(gnt0[1]), 32'h1);
    for (int j = 1; j < 8; j++) begin
      if (j == 1)      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h30, 32'h77);
      else if (j == 2) drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0);
      else             idle();
      @(negedge clk);
      rv0[j] = rvalid0[1]; rv1[j] = rvalid1[1];
      rd0[j] = rdata0[1];  rd1[j] = rdata1[1];
    end
    chk("t4_rvalid0_n4", 1, 32'(rv0[4]), 32'h1);
    chk("t4_rdata0_n4",  1, rd0[4], 32'hDEADBEEF);
    chk("t4_quiet_n5",   1, 32'(rv0[5] | rv1[5]), 32'h0);
    chk("t4_rvalid1_n6", 1, 32'(rv1[6]), 32'h1);
    chk("t4_rdata1_n6",  1, rd1[6], 32'h77);

    // Reset two cycles after a granted read on MEM_LAT=3
    drive(1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t5_gnt0", 1, 32'(gnt0[1]), 32'h1);
    idle();
    @(posedge clk);
    #1;
    reset = 1'b0;
    req0 = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("t5_rst_gnt0",     k, 32'(gnt0[k]), 32'h0);
      chk("t5_rst_mem_we",   k, 32'(mem_we[k]), 32'h0);
      chk("t5_rst_mem_addr", k, mem_addr[k], 32'h0);
      chk("t5_rst_wdata",    k, mem_wdata[k], 32'h0);
      chk("t5_rst_rvalid",   k, 32'(rvalid0[k] | rvalid1[k]), 32'h0);
      chk("t5_rst_rdata",    k, rdata0[k] | rdata1[k], 32'h0);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    req0 = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      idle();
      @(negedge clk);
      if (rvalid0[0] || rvalid1[0] || rvalid0[1] || rvalid1[1]) cnt++;
    end
    chk("t5_no_stale_rvalid", 1, 32'(cnt), 32'd0);

    // Randomized traffic; requests are held until granted
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      g0s = gnt0[0];
      g1s = gnt1[0];
      @(posedge clk);
      #1;
      if (!req0 || g0s) begin
        req0 = ($urandom_range(0, 9) < 6);
        we0 = 1'($urandom_range(0, 1));
        addr0 = $urandom;
        wdata0 = $urandom;
      end
      if (!req1 || g1s) begin
        req1 = ($urandom_range(0, 9) < 6);
        we1 = 1'($urandom_range(0, 1));
        addr1 = $urandom;
        wdata1 = $urandom;
      end
    end
    repeat (8) idle();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
